// File: rtl/handshake_ctrl_rr_merge.sv
// Round-robin merge of NUM_INPUTS control tokens onto one registered output channel.
// The output carries the index of the requester whose token is held.
module handshake_ctrl_rr_merge #(
    parameter int NUM_INPUTS  = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_INPUTS-1:0]  ins_valid,
    output logic [NUM_INPUTS-1:0]  ins_ready,
    output logic [INDEX_WIDTH-1:0] outs,
    output logic                   outs_valid,
    input  logic                   outs_ready
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

    logic                   out_full;
    logic [INDEX_WIDTH-1:0] out_idx;
    logic [INDEX_WIDTH-1:0] ptr;
    logic                   load;
    logic                   found;
    logic [INDEX_WIDTH-1:0] win;
    logic                   accept;
    logic [INDEX_WIDTH-1:0] ptr_next;

    // Reset gates load so no requester sees a grant while rst is low.
    assign load = rst & (~out_full | outs_ready);

    // Two passes give the rotated search: ptr..N-1 first, then 0..ptr-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (!found && ins_valid[j] && (INDEX_WIDTH'(j) >= ptr)) begin
                found = 1'b1;
                win   = INDEX_WIDTH'(j);
            end
        end
        for (int j = 0; j < NUM_INPUTS; j++) begin
            if (!found && ins_valid[j] && (INDEX_WIDTH'(j) < ptr)) begin
                found = 1'b1;
                win   = INDEX_WIDTH'(j);
            end
        end
    end

    always_comb begin
        ins_ready = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            ins_ready[j] = load & found & (win == INDEX_WIDTH'(j));
        end
    end

    assign accept   = load & found;
    assign ptr_next = (win == LAST_IDX) ? '0 : win + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_full <= 1'b0;
            out_idx  <= '0;
            ptr      <= '0;
        end else if (accept) begin
            out_full <= 1'b1;
            out_idx  <= win;
            ptr      <= ptr_next;
        end else if (outs_ready) begin
            out_full <= 1'b0;
        end
    end

    assign outs       = out_idx;
    assign outs_valid = out_full;

endmodule

// File: tb/tb_handshake_ctrl_rr_merge.sv
// Self-checking bench for handshake_ctrl_rr_merge: directed scenarios plus random traffic
// against a rotating-priority reference model.
module tb_handshake_ctrl_rr_merge;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  ins_valid;
    logic [N-1:0]  ins_ready;
    logic [IW-1:0] outs;
    logic          outs_valid;
    logic          outs_ready;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit m_rst;
    bit m_full;
    int m_idx;
    int m_ptr;

    handshake_ctrl_rr_merge #(.NUM_INPUTS(N), .INDEX_WIDTH(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_idx  = 0;
        m_ptr  = 0;
    endtask

    // Drive one cycle starting just after a rising edge; checks grant before the edge
    // and registered outputs just after it.
    task automatic step(input logic [N-1:0] v, input logic r);
        int w;
        logic [N-1:0] exp_rdy;
        bit acc;
        ins_valid  = v;
        outs_ready = r;
        #1;
        w = model_winner(v);
        acc = m_rst && (!m_full || r) && (w >= 0);
        exp_rdy = '0;
        if (acc) exp_rdy[w] = 1'b1;
        check("ins_ready", 32'(ins_ready), 32'(exp_rdy));
        @(posedge clk);
        if (acc) begin
            m_full = 1'b1;
            m_idx  = w;
            m_ptr  = (w + 1) % N;
        end else if (r) begin
            m_full = 1'b0;
        end
        #1;
        check("outs_valid", 32'(outs_valid), 32'(m_full));
        check("outs", 32'(outs), 32'(m_idx));
    endtask

    initial begin
        rst        = 1'b0;
        m_rst      = 1'b0;
        ins_valid  = 4'b1111;
        outs_ready = 1'b1;
        model_reset();
        #3;
        check("rst_outs_valid", 32'(outs_valid), 32'd0);
        check("rst_outs", 32'(outs), 32'd0);
        check("rst_ins_ready", 32'(ins_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ins_ready", 32'(ins_ready), 32'd0);
        check("rst_hold_outs_valid", 32'(outs_valid), 32'd0);

        ins_valid = '0;
        rst       = 1'b1;
        m_rst     = 1'b1;

        // round-robin stream
        repeat (8) step(4'b1111, 1'b1);
        // sparse plus wrap: grant 2 -> ptr 3, then 0 then 1
        step(4'b0100, 1'b1);
        step(4'b0011, 1'b1);
        step(4'b0011, 1'b1);
        // backpressure: hold token 2, then accept 3 with no bubble
        step(4'b0100, 1'b1);
        repeat (5) step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        // drain to empty, then priority must still favour input 2 over 0
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0101, 1'b1);
        check("drain_winner", 32'(outs), 32'd2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0));
        end

        // async reset mid-stream
        step(4'b1111, 1'b1);
        check("pre_reset_valid", 32'(outs_valid), 32'd1);
        #2;
        rst   = 1'b0;
        m_rst = 1'b0;
        model_reset();
        #1;
        check("async_outs_valid", 32'(outs_valid), 32'd0);
        check("async_outs", 32'(outs), 32'd0);
        check("async_ins_ready", 32'(ins_ready), 32'd0);
        @(posedge clk);
        #1;
        ins_valid = '0;
        rst       = 1'b1;
        m_rst     = 1'b1;
        step(4'b1110, 1'b1);
        check("post_reset_first", 32'(outs), 32'd1);
        step(4'b1110, 1'b1);
        step(4'b0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/handshake_ctrl_rr_merge.md
Name: handshake_ctrl_rr_merge

Overview:
- Round-robin control-token merge; shares one downstream control channel between NUM_INPUTS requesters.
- Typical use: sequencing several ctrl_valid producers onto a single handshake constant or other shared unit.
- Emits the winning input index with each token, so downstream can steer or select per-requester data.
- One-entry output register: 1-cycle latency, full throughput of 1 token/cycle.

Parameters:
- NUM_INPUTS, 4, number of requesting control channels (>=1, any value, not restricted to powers of 2).
- INDEX_WIDTH, 2, width of the index payload; must be >= clog2(NUM_INPUTS), and 1 when NUM_INPUTS=1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- ins_valid  input  NUM_INPUTS  per-requester token valid.
- ins_ready  output  NUM_INPUTS  per-requester accept.
- outs  output  INDEX_WIDTH  index of the requester whose token is held.
- outs_valid  output  1  output token valid.
- outs_ready  input  1  downstream accept.

Behaviour:
- State:
  - out_full (drives outs_valid).
  - out_idx (drives outs).
  - ptr: priority pointer, range 0..NUM_INPUTS-1.
- Reset (rst=0, asynchronous): out_full=0, out_idx=0, ptr=0, so outs_valid=0 and outs=0 immediately. ins_ready is then 0 for every input, because load is gated by reset.
- load = !out_full | outs_ready. The register is empty, or it drains in this cycle.
- Grant (combinational):
  - Winner w = first i with ins_valid[i]=1, searching ptr, ptr+1, ..., NUM_INPUTS-1, 0, ..., ptr-1.
  - No winner if ins_valid is all zero.
- ins_ready[i] = load & (i==w). At most one ins_ready bit is high in any cycle, and only for a valid requester.
- Accept event (some ins_valid[w] & ins_ready[w]):
  - Next cycle: out_full=1, out_idx=w.
  - ptr <= w+1, wrapping to 0 when w = NUM_INPUTS-1.
- Drain without accept (outs_valid & outs_ready, no winner): out_full <= 0; out_idx holds its last value.
- Simultaneous drain and accept: the old token leaves and the new token loads in the same edge. out_full stays 1 with no bubble.
- Stall (out_full & !outs_ready): all ins_ready=0. outs and outs_valid stay stable until accepted; ptr is frozen.
- ptr changes only on an accept event. Idle cycles never move priority.
- Fairness: with all inputs continuously valid and outs_ready=1, grants cycle 0,1,...,N-1,0... Each requester waits at most NUM_INPUTS-1 tokens.
- Combinational path: outs_ready -> ins_ready (through load) and ins_valid -> ins_ready (through grant). There is no path from ins_valid to outs_valid; the output is fully registered.
- A requester that drops ins_valid before being granted is simply skipped; the block does not check producer protocol.
- NUM_INPUTS=1: the block degenerates to a 1-deep register slice with outs=0.
- Reset asserted mid-operation: a held token is discarded and ptr returns to 0. There is no residual grant after reset deasserts.

Test Plan:
- Reset check: hold rst=0 with ins_valid=4'b1111 and outs_ready=1 -> outs_valid=0, outs=0, ins_ready=4'b0000. After release, the first accept is input 0 and outs=0 appears the next cycle.
- Round-robin stream: ins_valid=4'b1111 held, outs_ready=1 for 8 cycles -> outs sequence 0,1,2,3,0,1,2,3, outs_valid=1 every cycle after the first, exactly one ins_ready bit high per cycle.
- Sparse plus wrap: ptr=3 (after granting 2), ins_valid=4'b0011 -> input 0 granted. Next cycle with ins_valid=4'b0011 -> input 1 granted, ptr becomes 2.
- Backpressure: token from input 2 held while outs_ready=0 for 5 cycles, ins_valid=4'b1111 -> outs=2 stable, outs_valid=1, ins_ready=0. When outs_ready=1, input 3 is accepted in the same cycle with no bubble.
- Drain to empty: single token from input 1, then ins_valid=0 and outs_ready=1 -> outs_valid falls the next cycle and ptr stays 2. A later request on input 0 with input 2 also valid -> input 2 wins.
- Async reset mid-stream: assert rst=0 between clock edges while outs_valid=1 -> outs_valid drops to 0 without waiting for a clock edge. After release with ins_valid=4'b1110, input 1 is granted first.
